// File: rtl/bus_transfer_scheduler.sv
// bus_transfer_scheduler: queues bus transfer requests (req_*) and issues them as registered selectIn/dest_wr_en/dmem_rd_en with done/busy/err status
module bus_transfer_scheduler #(
  parameter int DEPTH = 4,
  parameter int SEL_WIDTH = 4,
  parameter int DEST_WIDTH = 8,
  parameter int DMEM_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [SEL_WIDTH-1:0]  req_src,
  input  logic [DEST_WIDTH-1:0] req_dest,
  output logic [SEL_WIDTH-1:0]  selectIn,
  output logic [DEST_WIDTH-1:0] dest_wr_en,
  output logic                  dmem_rd_en,
  output logic                  done,
  output logic                  busy,
  output logic                  err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DMEM_LAT + 1);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [SEL_WIDTH-1:0] SRC_DMEM = '0;
  localparam logic [SEL_WIDTH-1:0] SRC_IDLE = SEL_WIDTH'(9);
  typedef enum logic {IDLE, MEM_WAIT} state_t;
  state_t state_q, state_d;
  logic [SEL_WIDTH-1:0] src_mem [DEPTH];
  logic [DEST_WIDTH-1:0] dest_mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0] count_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DEST_WIDTH-1:0] hold_q, hold_d, wr_q, wr_d;
  logic [SEL_WIDTH-1:0] sel_q, sel_d;
  logic rd_q, rd_d, done_q, done_d, err_q, err_d, push, pop;
  logic [SEL_WIDTH-1:0] head_src;
  logic [DEST_WIDTH-1:0] head_dest;
  assign req_ready = count_q != FULL;
  assign push = req_valid && req_ready;
  assign head_src = src_mem[rd_ptr_q];
  assign head_dest = dest_mem[rd_ptr_q];
  assign selectIn = sel_q;
  assign dest_wr_en = wr_q;
  assign dmem_rd_en = rd_q;
  assign done = done_q;
  assign err = err_q;
  assign busy = (count_q != '0) || (state_q == MEM_WAIT) || done_q;
  always_ff @(posedge clk) begin
    if (push) begin
      src_mem[wr_ptr_q] <= req_src;
      dest_mem[wr_ptr_q] <= req_dest;
    end
  end
  // MEM_WAIT hands back to IDLE on the edge that registers the DMem done
  // outputs; IDLE then pops the next head on the following edge.
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    hold_d = hold_q;
    sel_d = SRC_IDLE;
    wr_d = '0;
    rd_d = 1'b0;
    done_d = 1'b0;
    err_d = err_q;
    pop = 1'b0;
    if (state_q == MEM_WAIT) begin
      sel_d = SRC_DMEM;
      if (cnt_q == CW'(1)) begin
        wr_d = hold_q;
        done_d = 1'b1;
        state_d = IDLE;
      end else cnt_d = cnt_q - CW'(1);
    end else if (count_q != '0) begin
      pop = 1'b1;
      if (head_src == SRC_DMEM) begin
        sel_d = SRC_DMEM;
        rd_d = 1'b1;
        hold_d = head_dest;
        cnt_d = CW'(DMEM_LAT);
        state_d = MEM_WAIT;
      end else if (head_src > SRC_IDLE) err_d = 1'b1;
      else begin
        sel_d = head_src;
        wr_d = head_dest;
        done_d = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      cnt_q <= '0;
      hold_q <= '0;
      sel_q <= SRC_IDLE;
      wr_q <= '0;
      rd_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_ptr_q <= push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_q <= pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_q <= count_q + (AW+1)'(push) - (AW+1)'(pop);
      cnt_q <= cnt_d;
      hold_q <= hold_d;
      sel_q <= sel_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_bus_transfer_scheduler.sv
// tb_bus_transfer_scheduler: directed scoreboard bench for bus_transfer_scheduler at DMEM_LAT=1 (a) and DMEM_LAT=3 (b)
module tb_bus_transfer_scheduler;
  logic clk = 1'b0;
  logic rstN = 1'b0;
  always #5 clk = ~clk;
  logic a_valid = 1'b0, b_valid = 1'b0;
  logic [3:0] a_src = '0, b_src = '0;
  logic [7:0] a_dest = '0, b_dest = '0;
  logic a_ready, a_rd, a_done, a_busy, a_err;
  logic b_ready, b_rd, b_done, b_busy, b_err;
  logic [3:0] a_sel, b_sel;
  logic [7:0] a_wr, b_wr;
  typedef struct packed {logic [3:0] s; logic [7:0] d;} exp_t;
  exp_t qa[$], qb[$];
  int tests = 0, fails = 0, a_since = 100, b_since = 100;
  logic [3:0] ss [6] = '{4'd0, 4'd1, 4'd0, 4'd5, 4'd7, 4'd0};
  logic [7:0] dd [6] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20};
  bus_transfer_scheduler #(.DEPTH(4), .SEL_WIDTH(4), .DEST_WIDTH(8), .DMEM_LAT(1)) u_a (
    .clk(clk), .rstN(rstN), .req_valid(a_valid), .req_ready(a_ready), .req_src(a_src),
    .req_dest(a_dest), .selectIn(a_sel), .dest_wr_en(a_wr), .dmem_rd_en(a_rd),
    .done(a_done), .busy(a_busy), .err(a_err));
  bus_transfer_scheduler #(.DEPTH(4), .SEL_WIDTH(4), .DEST_WIDTH(8), .DMEM_LAT(3)) u_b (
    .clk(clk), .rstN(rstN), .req_valid(b_valid), .req_ready(b_ready), .req_src(b_src),
    .req_dest(b_dest), .selectIn(b_sel), .dest_wr_en(b_wr), .dmem_rd_en(b_rd),
    .done(b_done), .busy(b_busy), .err(b_err));
  function automatic exp_t mk(input logic [3:0] s, input logic [7:0] d);
    mk.s = s;
    mk.d = d;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    exp_t e;
    @(posedge clk);
    #1;
    a_since = a_rd ? 0 : a_since + 1;
    b_since = b_rd ? 0 : b_since + 1;
    if (a_done) begin
      if (qa.size() == 0) chk("a_unexpected_done", 32'(a_done), 0);
      else begin
        e = qa.pop_front();
        chk("a_sel", 32'(a_sel), 32'(e.s));
        chk("a_wr", 32'(a_wr), 32'(e.d));
        if (e.s == 4'd0) chk("a_dmem_lat", a_since, 1);
      end
    end else chk("a_wr_quiet", 32'(a_wr), 0);
    if (b_done) begin
      if (qb.size() == 0) chk("b_unexpected_done", 32'(b_done), 0);
      else begin
        e = qb.pop_front();
        chk("b_sel", 32'(b_sel), 32'(e.s));
        chk("b_wr", 32'(b_wr), 32'(e.d));
        if (e.s == 4'd0) chk("b_dmem_lat", b_since, 3);
      end
    end else chk("b_wr_quiet", 32'(b_wr), 0);
  endtask
  initial begin
    int w;
    bit r;
    repeat (2) tick;
    rstN = 1'b1;
    tick;
    chk("rst_sel", 32'(a_sel), 9);
    chk("rst_wr", 32'(a_wr), 0);
    chk("rst_done", 32'(a_done), 0);
    chk("rst_busy", 32'(a_busy), 0);
    chk("rst_ready", 32'(a_ready), 1);
    chk("rst_err", 32'(a_err), 0);
    chk("rst_rd", 32'(a_rd), 0);
    chk("rst_b_sel", 32'(b_sel), 9);
    chk("rst_b_busy", 32'(b_busy), 0);
    a_valid = 1'b1; a_src = 4'd8; a_dest = 8'h01; qa.push_back(mk(4'd8, 8'h01));
    tick;
    a_valid = 1'b0;
    chk("ac_pending_done", 32'(a_done), 0);
    chk("ac_busy", 32'(a_busy), 1);
    tick;
    chk("ac_done", 32'(a_done), 1);
    chk("ac_sel", 32'(a_sel), 8);
    tick;
    chk("ac_after_sel", 32'(a_sel), 9);
    chk("ac_after_done", 32'(a_done), 0);
    chk("ac_after_busy", 32'(a_busy), 0);
    a_valid = 1'b1; a_src = 4'd0; a_dest = 8'h04; qa.push_back(mk(4'd0, 8'h04));
    tick;
    a_src = 4'd3; a_dest = 8'h10; qa.push_back(mk(4'd3, 8'h10));
    tick;
    a_valid = 1'b0;
    chk("dm_c1_sel", 32'(a_sel), 0);
    chk("dm_c1_rd", 32'(a_rd), 1);
    chk("dm_c1_done", 32'(a_done), 0);
    tick;
    chk("dm_c2_done", 32'(a_done), 1);
    chk("dm_c2_rd", 32'(a_rd), 0);
    chk("dm_c2_sel", 32'(a_sel), 0);
    tick;
    chk("dm_c3_sel", 32'(a_sel), 3);
    chk("dm_c3_done", 32'(a_done), 1);
    tick;
    chk("dm_idle_busy", 32'(a_busy), 0);
    for (int i = 0; i < 6; i++) begin
      b_valid = 1'b1; b_src = ss[i]; b_dest = dd[i];
      w = 0;
      do begin
        r = b_ready;
        tick;
        w++;
      end while (!r && w < 20);
      if (!r) chk("b_ready_timeout", 32'(b_ready), 1);
      else qb.push_back(mk(ss[i], dd[i]));
      if (i == 4) chk("b_full_ready", 32'(b_ready), 0);
    end
    b_valid = 1'b0;
    w = 0;
    while (b_busy && w < 60) begin
      tick;
      w++;
    end
    chk("b_drain_busy", 32'(b_busy), 0);
    chk("b_queue_empty", qb.size(), 0);
    a_valid = 1'b1; a_src = 4'd12; a_dest = 8'hff;
    tick;
    a_valid = 1'b0;
    tick;
    chk("ill_done", 32'(a_done), 0);
    chk("ill_sel", 32'(a_sel), 9);
    chk("ill_err", 32'(a_err), 1);
    a_valid = 1'b1; a_src = 4'd9; a_dest = 8'h80; qa.push_back(mk(4'd9, 8'h80));
    tick;
    a_src = 4'd2; a_dest = 8'h00; qa.push_back(mk(4'd2, 8'h00));
    tick;
    a_valid = 1'b0;
    repeat (3) tick;
    chk("err_sticky", 32'(a_err), 1);
    chk("ill_queue_empty", qa.size(), 0);
    b_valid = 1'b1; b_src = 4'd0; b_dest = 8'h01; qb.push_back(mk(4'd0, 8'h01));
    tick;
    b_src = 4'd1; b_dest = 8'h02; qb.push_back(mk(4'd1, 8'h02));
    tick;
    b_src = 4'd4; b_dest = 8'h03; qb.push_back(mk(4'd4, 8'h03));
    tick;
    b_valid = 1'b0;
    chk("pre_rst_busy", 32'(b_busy), 1);
    chk("pre_rst_sel", 32'(b_sel), 0);
    #2 rstN = 1'b0;
    #1;
    qa.delete();
    qb.delete();
    chk("arst_sel", 32'(b_sel), 9);
    chk("arst_rd", 32'(b_rd), 0);
    chk("arst_wr", 32'(b_wr), 0);
    chk("arst_done", 32'(b_done), 0);
    chk("arst_busy", 32'(b_busy), 0);
    chk("arst_ready", 32'(b_ready), 1);
    chk("arst_a_err", 32'(a_err), 0);
    repeat (2) tick;
    rstN = 1'b1;
    repeat (8) tick;
    chk("post_rst_busy", 32'(b_busy), 0);
    chk("post_rst_sel", 32'(b_sel), 9);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
